// File: rtl/down_timer.sv
// Loadable down-counting timer with optional auto-reload.
// Expiry is signalled by a valid/ready event, and a sticky flag records events lost while the consumer stalled.
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             wen,
  input  logic [WIDTH-1:0] dat,
  input  logic             arl,
  output logic [WIDTH-1:0] cnt,
  output logic             run,
  output logic             tc_vld,
  input  logic             tc_rdy,
  output logic             miss
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_rld;
  logic             r_tcVld;
  logic             r_miss;

  logic             w_event;
  logic [WIDTH-1:0] w_one;

  assign w_one   = {{(WIDTH-1){1'b0}}, 1'b1};
  // A load in the same cycle suppresses the terminal cycle entirely.
  assign w_event = (r_state == RUN) && cen && !wen && (r_cnt == w_one);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rld   <= '0;
      r_tcVld <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      if (wen) begin
        r_cnt   <= dat;
        r_rld   <= dat;
        r_state <= (dat != '0) ? RUN : IDLE;
      end else if (w_event) begin
        if (arl) begin
          r_cnt   <= r_rld;
          r_state <= RUN;
        end else begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      end else if ((r_state == RUN) && cen) begin
        r_cnt <= r_cnt - w_one;
      end

      if (w_event) begin
        r_tcVld <= 1'b1;
      end else if (tc_rdy) begin
        r_tcVld <= 1'b0;
      end

      // Load clears the sticky flag even when an overflow occurs in the same cycle.
      if (wen) begin
        r_miss <= 1'b0;
      end else if (w_event && r_tcVld && !tc_rdy) begin
        r_miss <= 1'b1;
      end
    end
  end

  assign cnt    = r_cnt;
  assign run    = (r_state == RUN);
  assign tc_vld = r_tcVld;
  assign miss   = r_miss;

endmodule

// File: tb/tb_down_timer.sv
// Directed testbench for down_timer: hand-computed vectors checked on the falling edge.
module tb_down_timer;

  logic       clk;
  logic       rst;
  logic       cen;
  logic       wen;
  logic [7:0] dat;
  logic       arl;
  logic [7:0] cnt;
  logic       run;
  logic       tc_vld;
  logic       tc_rdy;
  logic       miss;

  int vectors;
  int miscompares;

  down_timer #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .cen    (cen),
    .wen    (wen),
    .dat    (dat),
    .arl    (arl),
    .cnt    (cnt),
    .run    (run),
    .tc_vld (tc_vld),
    .tc_rdy (tc_rdy),
    .miss   (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs after a falling edge, then returns on the next falling edge.
  task automatic applyStimulus(input logic iWen, input logic [7:0] iDat, input logic iCen,
                               input logic iArl, input logic iRdy);
    wen    = iWen;
    dat    = iDat;
    cen    = iCen;
    arl    = iArl;
    tc_rdy = iRdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkAll(input string tag, input logic [7:0] eCnt, input logic eRun,
                          input logic eVld, input logic eMiss);
    checkOutput({tag, ".cnt"}, {24'd0, cnt}, {24'd0, eCnt});
    checkOutput({tag, ".run"}, {31'd0, run}, {31'd0, eRun});
    checkOutput({tag, ".vld"}, {31'd0, tc_vld}, {31'd0, eVld});
    checkOutput({tag, ".miss"}, {31'd0, miss}, {31'd0, eMiss});
  endtask

  initial begin
    logic [7:0] expCnt[8];
    logic       expVld[8];
    logic       cenPat[8];

    vectors     = 0;
    miscompares = 0;
    rst = 1'b0; cen = 1'b0; wen = 1'b0; dat = '0; arl = 1'b0; tc_rdy = 1'b0;

    // Reset and one-shot countdown.
    repeat (2) @(negedge clk);
    checkAll("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
    checkAll("load3", 8'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkAll("os2", 8'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkAll("os1", 8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkAll("os0", 8'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    checkAll("osHold", 8'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
    checkAll("osAccept", 8'd0, 1'b0, 1'b0, 1'b0);

    // Auto-reload period 4 with continuous enable.
    applyStimulus(1'b1, 8'd4, 1'b1, 1'b1, 1'b1);
    checkAll("arLoad", 8'd4, 1'b1, 1'b0, 1'b0);
    expCnt = '{8'd3, 8'd2, 8'd1, 8'd4, 8'd3, 8'd2, 8'd1, 8'd4};
    expVld = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
      checkOutput($sformatf("ar%0d.cnt", i), {24'd0, cnt}, {24'd0, expCnt[i]});
      checkOutput($sformatf("ar%0d.vld", i), {31'd0, tc_vld}, {31'd0, expVld[i]});
    end

    // Half-rate enable stretches the period to 8 clocks.
    expCnt = '{8'd4, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1, 8'd4};
    expVld = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cenPat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'd0, cenPat[i], 1'b1, 1'b1);
      checkOutput($sformatf("half%0d.cnt", i), {24'd0, cnt}, {24'd0, expCnt[i]});
      checkOutput($sformatf("half%0d.vld", i), {31'd0, tc_vld}, {31'd0, expVld[i]});
    end

    // Missed event while the consumer stalls, cleared by a load.
    applyStimulus(1'b1, 8'd2, 1'b1, 1'b1, 1'b1);
    checkAll("mLoad", 8'd2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    checkAll("m1", 8'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    checkAll("mEv1", 8'd2, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    checkAll("m3", 8'd1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    checkAll("mEv2", 8'd2, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'd5, 1'b1, 1'b1, 1'b0);
    checkAll("mClr", 8'd5, 1'b1, 1'b1, 1'b0);

    // Reload of 1: accept and new event coincide every cycle.
    applyStimulus(1'b1, 8'd1, 1'b1, 1'b1, 1'b1);
    checkAll("r1Load", 8'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
      checkAll($sformatf("r1_%0d", i), 8'd1, 1'b1, 1'b1, 1'b0);
    end

    // Load priority over decrement, then a zero load.
    applyStimulus(1'b1, 8'd8, 1'b1, 1'b0, 1'b1);
    checkAll("pLoad", 8'd8, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 1'b1);
    checkAll("p6", 8'd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd9, 1'b1, 1'b0, 1'b1);
    checkAll("p9", 8'd9, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd0, 1'b1, 1'b0, 1'b1);
    checkAll("zLoad", 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
      checkAll($sformatf("idle%0d", i), 8'd0, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset between edges with an event pending and miss set.
    applyStimulus(1'b1, 8'd2, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
    checkAll("preRst", 8'd2, 1'b1, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1 checkAll("asyncRst", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 1'b1);
      checkAll($sformatf("postRst%0d", i), 8'd0, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Loadable down-counting timer; the counting-down counterpart of the team's up-counter.
- Software or an FSM loads a count value. The timer decrements on each enabled cycle.
- At expiry it raises a terminal-count event, held under a valid/ready handshake until a consumer (interrupt controller or sequencer) takes it.
- Optional auto-reload gives a periodic tick. A sticky flag records events lost while the consumer stalled.

Parameters:
WIDTH, 8, width of count, load data and reload register

Ports:
clk  input  1  system clock; all state changes on posedge
rst  input  1  asynchronous reset, active-low (0 = reset)
cen  input  1  count enable; one decrement per cycle when high in RUN
wen  input  1  write enable; loads dat into counter and reload register
dat  input  WIDTH  load value
arl  input  1  auto-reload enable; sampled on the terminal cycle
cnt  output  WIDTH  current count value (registered)
run  output  1  1 in RUN state, 0 in IDLE
tc_vld  output  1  terminal-count event pending
tc_rdy  input  1  consumer accepts event when tc_vld & tc_rdy
miss  output  1  sticky: event raised while previous one still pending

Behaviour:
- Reset (rst low, asynchronous, any state):
  - cnt=0, internal rld=0, run=0, tc_vld=0, miss=0, state=IDLE.
  - Takes effect immediately, mid-count or mid-handshake. No event is generated on reset exit.
- States:
  - IDLE: counter stopped; cen ignored.
  - RUN: counter decrements on cen.
- Load, with priority over everything else in the counter path:
  - wen=1: cnt<=dat, rld<=dat, miss<=0.
  - Next state is RUN if dat!=0, else IDLE.
  - cen in the same cycle is ignored.
  - tc_vld is unaffected by wen; a pending event still follows the handshake.
- Count, in RUN with cen=1 and wen=0:
  - cnt>1: cnt<=cnt-1.
  - cnt==1 (terminal cycle): raise event.
    - arl=1: cnt<=rld, stay RUN.
    - arl=0: cnt<=0, go IDLE.
- With arl=1, an event occurs every rld enabled cycles:
  - rld=1 gives an event on every enabled cycle.
  - rld wrap is impossible since the count never passes below 1 in RUN.
- Arithmetic is unsigned WIDTH-bit; no underflow path exists.
- Latency: tc_vld rises on the clock edge that ends the terminal cycle, the same edge cnt takes rld/0.
- Handshake (per cycle, event = terminal cycle occurring):
  - tc_vld=0, event: tc_vld<=1.
  - tc_vld=1, tc_rdy=1, no event: tc_vld<=0.
  - tc_vld=1, tc_rdy=1, event: tc_vld stays 1 (new event replaces accepted one); miss unchanged.
  - tc_vld=1, tc_rdy=0, event: tc_vld stays 1; miss<=1.
  - tc_rdy while tc_vld=0: no effect.
- miss is cleared only by reset or wen. A miss set and a wen in the same cycle leave miss=0 (wen wins).
- run equals (state==RUN).
- cnt is stable in IDLE and when cen=0.

Test Plan:
- Reset/load: hold rst=0 → all outputs 0. Release, wen with dat=3, arl=0, cen=1 continuous → cnt 3,2,1,0. tc_vld=1 the cycle cnt shows 0, run=0 same cycle. tc_rdy=1 → tc_vld drops next edge.
- Auto-reload: dat=4, arl=1, cen=1, tc_rdy=1 → cnt 4,3,2,1,4,3,… with tc_vld high one cycle every 4 cycles. Toggle cen 50% → period becomes 8 clocks.
- Missed event: dat=2, arl=1, tc_rdy=0 → first event sets tc_vld. Second event 2 cycles later sets miss=1; tc_vld stays 1. wen dat=5 → miss=0.
- Simultaneous accept and new event: dat=1, arl=1, cen=1, tc_rdy=1 → tc_vld stays 1 continuously, miss stays 0.
- Load priority/zero load: in RUN at cnt=6, wen dat=9 with cen=1 → cnt=9 (no decrement). wen dat=0 → cnt=0, run=0, no event. cen pulses in IDLE → cnt stays 0.
- Async reset mid-operation: assert rst=0 between clock edges at cnt=2 with tc_vld=1, miss=1 → all outputs 0 immediately. After release, no event until the next wen.
